// File: rtl/pre_alu_loader.sv
// pre_alu_loader: streams A, B and op select into pre_ALU and captures its result under a valid/ack handshake
module pre_alu_loader #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             sel,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [2:0] {S_A, S_B, S_SEL, S_EXEC, S_HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic sel_q, sel_d, result_valid_q, result_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic xfer, done;
  assign xfer = data_valid & data_ready;
  assign done = (state_q == S_HOLD) & result_ack;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_A;
    else state_q <= state_d;
  // next-state: load three words, one settle cycle, then hold until acked
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:     state_d = xfer ? S_B : S_A;
      S_B:     state_d = xfer ? S_SEL : S_B;
      S_SEL:   state_d = xfer ? S_EXEC : S_SEL;
      S_EXEC:  state_d = S_HOLD;
      S_HOLD:  state_d = result_ack ? S_A : S_HOLD;
      default: state_d = S_A;
    endcase
  end
  // ready is a pure state decode so it never depends on data_valid
  always_comb data_ready = (state_q == S_A) | (state_q == S_B) | (state_q == S_SEL);
  // each operand register changes only on its own capture edge
  always_comb begin
    a_d            = (state_q == S_A && xfer) ? data_in : a_q;
    b_d            = (state_q == S_B && xfer) ? data_in : b_q;
    sel_d          = (state_q == S_SEL && xfer) ? data_in[0] : sel_q;
    result_d       = (state_q == S_EXEC) ? C : result_q;
    result_valid_d = (state_q == S_EXEC) ? 1'b1 : (done ? 1'b0 : result_valid_q);
    op_count_d     = op_count_q + {{(CNT_W-1){1'b0}}, done};
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q            <= '0;
      b_q            <= '0;
      sel_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      a_q            <= a_d;
      b_q            <= b_d;
      sel_q          <= sel_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      op_count_q     <= op_count_d;
    end
  assign A            = a_q;
  assign B            = b_q;
  assign sel          = sel_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign op_count     = op_count_q;
endmodule

// File: tb/tb_pre_alu_loader.sv
// tb_pre_alu_loader: directed vector bench for pre_alu_loader with a pre_ALU model
module tb_pre_alu_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] data_in = '0, A, B, C, result;
  logic data_valid = 1'b0, data_ready, sel, result_valid, result_ack = 1'b0;
  logic [7:0] op_count, exp_cnt = '0;
  int checks = 0, failures = 0;

  typedef struct {
    logic [3:0] a, b, s;
    logic       esel;
    logic [3:0] r;
    int         hold, gaps;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  // pre_ALU: add (carry lost) or AND
  assign C = sel ? (A & B) : (A + B);

  pre_alu_loader #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .A(A), .B(B), .sel(sel), .C(C),
    .result(result), .result_valid(result_valid), .result_ack(result_ack),
    .op_count(op_count)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // called and returns at a negedge; word transfers at the posedge in between
  task automatic send(logic [3:0] w);
    int t = 0;
    data_in = w;
    data_valid = 1'b1;
    result_ack = 1'b0;
    while (!data_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", data_ready, 1);
    @(negedge clk);
  endtask

  // idle cycles with junk data and stray acks that must be ignored
  task automatic gap(int n);
    repeat (n) begin
      data_valid = 1'b0;
      data_in = 4'($urandom);
      result_ack = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic op(vec_t v, bit full);
    gap(v.gaps);
    send(v.a);
    if (full) chk("load_A", A, v.a);
    gap(v.gaps);
    send(v.b);
    if (full) chk("load_B", B, v.b);
    gap(v.gaps);
    send(v.s);
    data_in = 4'($urandom);
    data_valid = 1'b1;
    if (full) begin
      chk("exec_ready", data_ready, 0);
      chk("exec_valid", result_valid, 0);
      chk("op_count_pre", op_count, exp_cnt);
    end
    @(negedge clk);
    chk("result_valid", result_valid, 1);
    chk("result", result, v.r);
    if (full) begin
      chk("sel", sel, v.esel);
      chk("A_hold", A, v.a);
      chk("B_hold", B, v.b);
      chk("hold_ready", data_ready, 0);
    end
    repeat (v.hold) begin
      data_valid = 1'($urandom);
      data_in = 4'($urandom);
      @(negedge clk);
    end
    if (v.hold > 0) begin
      chk("hold_result", result, v.r);
      chk("hold_valid", result_valid, 1);
      chk("hold_A", A, v.a);
      chk("hold_B", B, v.b);
      chk("hold_sel", sel, v.esel);
    end
    data_valid = 1'b0;
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    exp_cnt++;
    chk("ack_valid", result_valid, 0);
    chk("op_count", op_count, exp_cnt);
    chk("ack_ready", data_ready, 1);
  endtask

  initial begin
    vecs[0] = '{a: 4'h1, b: 4'h1, s: 4'h0, esel: 1'b0, r: 4'h2, hold: 0, gaps: 0};
    vecs[1] = '{a: 4'h7, b: 4'h3, s: 4'h1, esel: 1'b1, r: 4'h3, hold: 0, gaps: 0};
    vecs[2] = '{a: 4'h7, b: 4'h3, s: 4'h0, esel: 1'b0, r: 4'hA, hold: 0, gaps: 0};
    vecs[3] = '{a: 4'hD, b: 4'h6, s: 4'hE, esel: 1'b0, r: 4'h3, hold: 10, gaps: 0};
    vecs[4] = '{a: 4'hF, b: 4'hB, s: 4'h1, esel: 1'b1, r: 4'hB, hold: 0, gaps: 2};
    vecs[5] = '{a: 4'h9, b: 4'hC, s: 4'h1, esel: 1'b1, r: 4'h8, hold: 2, gaps: 1};
    #12;
    chk("rst_A", A, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_count", op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rel_ready", data_ready, 1);
    chk("rel_result", result, 0);
    for (int i = 0; i < 6; i++) op(vecs[i], 1'b1);
    send(4'h4);
    send(4'h1);
    chk("mid_A", A, 4'h4);
    chk("mid_ready", data_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_A", A, 0);
    chk("async_B", B, 0);
    chk("async_result", result, 0);
    chk("async_count", op_count, 0);
    chk("async_sel", sel, 0);
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    chk("post_ready", data_ready, 1);
    chk("post_valid", result_valid, 0);
    chk("post_count", op_count, 0);
    for (int i = 0; i < 255; i++)
      op('{a: 4'h2, b: 4'h3, s: 4'h0, esel: 1'b0, r: 4'h5, hold: 0, gaps: 0}, 1'b0);
    chk("count_ff", op_count, 8'hFF);
    op('{a: 4'h2, b: 4'h3, s: 4'h0, esel: 1'b0, r: 4'h5, hold: 0, gaps: 0}, 1'b0);
    chk("count_wrap", op_count, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
